// File: rtl/pwm_sample_modulator.sv
// pwm_sample_modulator
//
// Buffers unsigned PCM samples in a small FIFO and plays each one as a
// 1-bit PWM stream for REPEAT periods of 2^DATA_W clocks. Playback starts
// once the FIFO holds PRIME_LVL samples. It stops cleanly at the end of a
// PWM period when enable drops.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-low reset
//   enable     in   playback enable
//   s_data     in   PCM sample (unsigned, 0 = silence)
//   s_valid    in   s_data valid
//   s_ready    out  FIFO not full (combinational from level)
//   pwm_out    out  registered PWM bitstream
//   underrun   out  one-cycle pulse: sample boundary with FIFO empty
//   fifo_level out  current FIFO occupancy
//   busy       out  high while priming or playing

module pwm_sample_modulator #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int REPEAT     = 4,
    parameter int PRIME_LVL  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          pwm_out,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [DATA_W-1:0] head;

    // ------------------------------------------------------------------
    // Playback state
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [DATA_W-1:0] cnt_q;
    logic [REP_W-1:0]  rep_q;
    logic [DATA_W-1:0] duty_q;
    logic              pwm_q;
    logic              underrun_q;

    logic              period_end;
    logic              sample_end;
    logic              prime_load;
    logic              run_load;
    logic              run_underrun;

    assign s_ready    = (level_q != LVL_W'(FIFO_DEPTH));
    assign push       = s_valid && s_ready;
    assign fifo_empty = (level_q == '0);
    assign head       = mem_q[rd_ptr_q];

    // A sample boundary is the last clock of the last repeat period.
    assign period_end   = (state_q == RUN) && (cnt_q == '1);
    assign sample_end   = period_end && (rep_q == REP_W'(REPEAT - 1));

    // Dropping enable wins over any load or underrun at the boundary.
    assign prime_load   = (state_q == PRIME) && enable && (level_q >= LVL_W'(PRIME_LVL));
    assign run_load     = sample_end && enable && !fifo_empty;
    assign run_underrun = sample_end && enable && fifo_empty;
    assign pop          = prime_load || run_load;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // NOTE: sample storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // NOTE: reset is sampled on the clock edge (synchronous), and all state uses <=.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

    // ------------------------------------------------------------------
    // Playback FSM with registered PWM compare
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rep_q      <= '0;
            duty_q     <= '0;
            pwm_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    pwm_q <= 1'b0;
                    cnt_q <= '0;
                    rep_q <= '0;
                    if (enable) begin
                        state_q <= PRIME;
                    end
                end

                PRIME: begin
                    pwm_q <= 1'b0;
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (prime_load) begin
                        duty_q  <= head;
                        cnt_q   <= '0;
                        rep_q   <= '0;
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    if (period_end && !enable) begin
                        // Period finished while disabled: park without popping.
                        state_q <= IDLE;
                        pwm_q   <= 1'b0;
                        cnt_q   <= '0;
                        rep_q   <= '0;
                    end else begin
                        // Compare uses the current count, so pwm_out trails cnt by one clock.
                        pwm_q <= (cnt_q < duty_q);
                        cnt_q <= cnt_q + 1'b1;
                        if (sample_end) begin
                            rep_q <= '0;
                        end else if (period_end) begin
                            rep_q <= rep_q + 1'b1;
                        end
                        if (run_load) begin
                            duty_q <= head;
                        end
                        if (run_underrun) begin
                            underrun_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    pwm_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pwm_out    = pwm_q;
    assign underrun   = underrun_q;
    assign fifo_level = level_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_sample_modulator.sv
// tb_pwm_sample_modulator
//
// Directed bench for pwm_sample_modulator with default parameters
// (DATA_W=8, FIFO_DEPTH=4, REPEAT=4, PRIME_LVL=2). Inputs are driven and
// outputs sampled on the falling clock edge.

module tb_pwm_sample_modulator;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       pwm_out;
    logic       underrun;
    logic [2:0] fifo_level;
    logic       busy;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] sample;
        int         exp_high;
    } duty_vec_t;

    duty_vec_t vecs [8];

    pwm_sample_modulator #(
        .DATA_W    (8),
        .FIFO_DEPTH(4),
        .REPEAT    (4),
        .PRIME_LVL (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .pwm_out   (pwm_out),
        .underrun  (underrun),
        .fifo_level(fifo_level),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        enable  = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic push(input logic [7:0] d);
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
    endtask

    // Four samples, four periods each; the boundary after the last one underruns.
    task automatic run_duty_batch(input int base);
        int hi;
        int und_early;
        do_reset();
        for (int i = 0; i < 4; i++) push(vecs[base + i].sample);
        check("batch_level_full", fifo_level, 4);
        check("batch_ready_full", s_ready, 0);
        enable = 1'b1;
        tick();
        tick();
        check("batch_level_after_load", fifo_level, 3);
        und_early = 0;
        for (int p = 0; p < 16; p++) begin
            hi = 0;
            for (int j = 1; j <= 256; j++) begin
                int k;
                tick();
                k = 256 * p + j;
                if (pwm_out) hi++;
                if (k < 4096 && underrun) und_early++;
                if (k == 4096) check("batch_underrun_at_end", underrun, 1);
            end
            check($sformatf("duty_%0d_period_%0d", vecs[base + p / 4].sample, p % 4),
                  hi, vecs[base + p / 4].exp_high);
        end
        check("batch_no_early_underrun", und_early, 0);
        check("batch_level_empty", fifo_level, 0);
        enable = 1'b0;
    endtask

    initial begin
        int hi;
        int hi2;
        int und_pulses;
        int und_bad;
        int busy_bad;
        int bp_hi [5];
        logic [7:0] bp_exp [5];

        checks = 0;
        errors = 0;

        vecs[0] = '{8'd64,  64};
        vecs[1] = '{8'd0,   0};
        vecs[2] = '{8'd255, 255};
        vecs[3] = '{8'd128, 128};
        vecs[4] = '{8'd1,   1};
        vecs[5] = '{8'd254, 254};
        vecs[6] = '{8'd2,   2};
        vecs[7] = '{8'd200, 200};

        // ---------------- Reset with live inputs ----------------
        rst     = 1'b0;
        enable  = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_pwm_%0d", i),   pwm_out, 0);
            check($sformatf("reset_level_%0d", i), fifo_level, 0);
            check($sformatf("reset_ready_%0d", i), s_ready, 1);
            check($sformatf("reset_busy_%0d", i),  busy, 0);
        end
        check("reset_underrun", underrun, 0);

        // ---------------- Duty accuracy, table-driven ----------------
        run_duty_batch(0);
        run_duty_batch(4);

        // ---------------- Priming ----------------
        do_reset();
        enable = 1'b1;
        tick();
        check("prime_busy", busy, 1);
        push(8'd50);
        for (int i = 0; i < 5; i++) tick();
        check("prime_hold_busy",  busy, 1);
        check("prime_hold_pwm",   pwm_out, 0);
        check("prime_hold_level", fifo_level, 1);
        push(8'd150);
        check("prime_level_two", fifo_level, 2);
        check("prime_pwm_two",   pwm_out, 0);
        tick();
        check("prime_load_level", fifo_level, 1);
        check("prime_load_pwm",   pwm_out, 0);
        tick();
        check("prime_first_rise", pwm_out, 1);
        hi = 1;
        for (int j = 2; j <= 256; j++) begin
            tick();
            if (pwm_out) hi++;
        end
        check("prime_first_period", hi, 50);

        // ---------------- Underrun ----------------
        do_reset();
        push(8'd100);
        push(8'd200);
        enable = 1'b1;
        tick();
        tick();
        hi = 0;
        hi2 = 0;
        und_pulses = 0;
        und_bad = 0;
        for (int k = 1; k <= 5120; k++) begin
            logic boundary;
            tick();
            boundary = (k == 2048) || (k == 3072) || (k == 4096) || (k == 5120);
            if (underrun) und_pulses++;
            if (underrun != boundary) und_bad++;
            if (k <= 256 && pwm_out) hi++;
            if (k >= 4097 && k <= 4352 && pwm_out) hi2++;
            if (k == 2304) check("underrun_hold_period", hi, 100);
        end
        check("underrun_first_sample", hi, 100);
        check("underrun_duty_held", hi2, 200);
        check("underrun_pulse_count", und_pulses, 4);
        check("underrun_pulse_misplaced", und_bad, 0);
        check("underrun_level", fifo_level, 0);
        check("underrun_busy", busy, 1);
        enable = 1'b0;

        // ---------------- Backpressure ----------------
        do_reset();
        for (int i = 0; i < 4; i++) push(8'((i + 1) * 10));
        check("bp_level_full", fifo_level, 4);
        check("bp_ready_low",  s_ready, 0);
        s_valid = 1'b1;
        s_data  = 8'd50;
        for (int i = 0; i < 3; i++) tick();
        check("bp_level_held", fifo_level, 4);
        check("bp_ready_held", s_ready, 0);
        enable = 1'b1;
        tick();
        check("bp_prime_level", fifo_level, 4);
        tick();
        check("bp_pop_level", fifo_level, 3);
        check("bp_pop_ready", s_ready, 1);
        for (int j = 0; j < 5; j++) begin
            bp_hi[j]  = 0;
            bp_exp[j] = 8'((j + 1) * 10);
        end
        for (int k = 1; k <= 4352; k++) begin
            tick();
            if (k == 1) begin
                check("bp_fifth_level", fifo_level, 4);
                check("bp_fifth_ready", s_ready, 0);
                s_valid = 1'b0;
            end
            if (((k - 1) % 1024) < 256 && pwm_out) bp_hi[(k - 1) / 1024]++;
        end
        for (int j = 0; j < 5; j++) begin
            check($sformatf("bp_order_%0d", j), bp_hi[j], bp_exp[j]);
        end
        enable = 1'b0;

        // ---------------- Stop mid-period ----------------
        do_reset();
        push(8'd90);
        push(8'd180);
        enable = 1'b1;
        tick();
        tick();
        for (int k = 1; k <= 10; k++) tick();
        enable = 1'b0;
        hi = 0;
        busy_bad = 0;
        for (int k = 11; k <= 255; k++) begin
            tick();
            if (pwm_out) hi++;
            if (!busy) busy_bad++;
        end
        check("stop_tail_high", hi, 80);
        check("stop_tail_busy", busy_bad, 0);
        tick();
        check("stop_wrap_pwm",      pwm_out, 0);
        check("stop_wrap_busy",     busy, 0);
        check("stop_wrap_level",    fifo_level, 1);
        check("stop_wrap_underrun", underrun, 0);
        tick();
        check("stop_idle_busy", busy, 0);
        enable = 1'b1;
        tick();
        check("restart_busy", busy, 1);
        check("restart_pwm",  pwm_out, 0);
        for (int i = 0; i < 3; i++) tick();
        check("restart_prime_busy",  busy, 1);
        check("restart_prime_level", fifo_level, 1);
        check("restart_prime_pwm",   pwm_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
